// File: rtl/channel_lock_detector_pkg.sv
// Shared types and default sizing for the channel lock detector.
package channel_lock_detector_pkg;

  typedef enum logic [1:0] {
    LOCK_IDLE    = 2'b00,
    LOCK_PULL_IN = 2'b01,
    LOCK_LOCKED  = 2'b10,
    LOCK_LOST    = 2'b11
  } lock_state_e;

  localparam int DEF_ACC_W          = 16;
  localparam int DEF_I2Q2_W         = 32;
  localparam int DEF_SCORE_W        = 6;
  localparam int DEF_SCORE_MAX      = 40;
  localparam int DEF_LOCK_THRESH    = 20;
  localparam int DEF_UNLOCK_THRESH  = 8;
  localparam int DEF_LOSS_PENALTY   = 2;
  localparam int DEF_PULLIN_TIMEOUT = 200;
  localparam int DEF_RATIO_SHIFT    = 1;
  localparam int HIST_W             = 16;

endpackage

// File: rtl/channel_lock_detector_abs_sat.sv
// Saturating absolute value: the most negative input maps to the largest positive value.
module abs_sat #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] x,
  output logic        [W-1:0] y
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  always_comb begin
    if (!x[W-1]) begin
      y = $unsigned(x);
    end else if ($unsigned(x) == MOST_NEG) begin
      y = MAX_POS;
    end else begin
      y = $unsigned(-x);
    end
  end

endmodule

// File: rtl/channel_lock_detector.sv
// Per-channel carrier/code lock judge, evaluated once per tracking epoch through a two-stage pipeline.
// Define CHANNEL_LOCK_HISTORY_EN to keep a 16-epoch shift register of pass bits on lock_history.
//
// state    | meaning
// IDLE     | no epoch evaluated since reset / mode change
// PULL_IN  | loops converging; score must reach lock threshold before timeout
// LOCKED   | lock held; nav-bit extraction may proceed
// LOST     | sticky loss; re-acquisition required (cleared only by resets)
module channel_lock_detector
  import channel_lock_detector_pkg::*;
#(
  parameter int ACC_W          = DEF_ACC_W,
  parameter int I2Q2_W         = DEF_I2Q2_W,
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int SCORE_MAX      = DEF_SCORE_MAX,
  parameter int LOCK_THRESH    = DEF_LOCK_THRESH,
  parameter int UNLOCK_THRESH  = DEF_UNLOCK_THRESH,
  parameter int LOSS_PENALTY   = DEF_LOSS_PENALTY,
  parameter int PULLIN_TIMEOUT = DEF_PULLIN_TIMEOUT,
  parameter int RATIO_SHIFT    = DEF_RATIO_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode_reset,
  input  logic                      tracking_ready,
  input  logic signed [ACC_W-1:0]   i_prompt_k,
  input  logic signed [ACC_W-1:0]   q_prompt_k,
  input  logic        [I2Q2_W-1:0]  i2q2_prompt,
  input  logic        [I2Q2_W-1:0]  power_thresh,
  output logic        [1:0]         lock_state,
  output logic                      locked,
  output logic                      lost,
  output logic                      lost_strobe,
  output logic        [SCORE_W-1:0] lock_score,
  output logic        [15:0]        epoch_count,
  output logic        [HIST_W-1:0]  lock_history
);

  localparam int                 PI_W      = $clog2(PULLIN_TIMEOUT + 1);
  localparam logic [PI_W-1:0]    PI_LOAD   = PI_W'(PULLIN_TIMEOUT);
  localparam logic [PI_W-1:0]    PI_LAST   = PI_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] LOCK_V    = SCORE_W'(LOCK_THRESH);
  localparam logic [SCORE_W-1:0] UNLOCK_V  = SCORE_W'(UNLOCK_THRESH);
  localparam logic [SCORE_W-1:0] PENALTY_V = SCORE_W'(LOSS_PENALTY);

  logic                clear;
  logic [ACC_W-1:0]    abs_i_c, abs_q_c;
  logic [ACC_W-1:0]    abs_i_q, abs_q_q;
  logic                power_ok_q, valid1_q;
  logic [ACC_W:0]      mag_i, mag_q_thr;
  logic                pass;
  logic [SCORE_W-1:0]  score_q, score_nxt;
  logic [15:0]         epoch_q;
  logic [PI_W-1:0]     pullin_left_q;
  logic                pullin_done;
  logic                lost_strobe_q;
  lock_state_e         state_q, state_nxt;

  assign clear = !reset_n || mode_reset;

  abs_sat #(.W(ACC_W)) u_abs_i (.x(i_prompt_k), .y(abs_i_c));
  abs_sat #(.W(ACC_W)) u_abs_q (.x(q_prompt_k), .y(abs_q_c));

  // Stage 1: magnitudes and power test
  always_ff @(posedge clk) begin
    if (clear) begin
      valid1_q   <= 1'b0;
      abs_i_q    <= '0;
      abs_q_q    <= '0;
      power_ok_q <= 1'b0;
    end else begin
      valid1_q <= tracking_ready;
      if (tracking_ready) begin
        abs_i_q    <= abs_i_c;
        abs_q_q    <= abs_q_c;
        power_ok_q <= (i2q2_prompt >= power_thresh);
      end
    end
  end

  // One extra bit so |Q| + |Q|/2^k cannot overflow
  assign mag_i     = {1'b0, abs_i_q};
  assign mag_q_thr = {1'b0, abs_q_q} + {1'b0, (abs_q_q >> RATIO_SHIFT)};
  assign pass      = (mag_i > mag_q_thr) && power_ok_q;

  always_comb begin
    score_nxt = score_q;
    if (pass) begin
      if (score_q >= SCORE_TOP) score_nxt = SCORE_TOP;
      else                      score_nxt = score_q + 1'b1;
    end else begin
      if (score_q < PENALTY_V) score_nxt = '0;
      else                     score_nxt = score_q - PENALTY_V;
    end
  end

  assign pullin_done = (pullin_left_q == PI_LAST);

  always_ff @(posedge clk) begin
    if (clear) state_q <= LOCK_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (valid1_q) begin
      case (state_q)
        LOCK_IDLE:    state_nxt = LOCK_PULL_IN;
        LOCK_PULL_IN: begin
          if (score_nxt >= LOCK_V)  state_nxt = LOCK_LOCKED;
          else if (pullin_done)     state_nxt = LOCK_LOST;
        end
        LOCK_LOCKED:  if (score_nxt < UNLOCK_V) state_nxt = LOCK_LOST;
        default:      state_nxt = state_q;
      endcase
    end
  end

  // Stage 2: score, counters, strobe
  always_ff @(posedge clk) begin
    if (clear) begin
      score_q       <= '0;
      epoch_q       <= '0;
      pullin_left_q <= PI_LOAD;
      lost_strobe_q <= 1'b0;
    end else begin
      lost_strobe_q <= (state_nxt == LOCK_LOST) && (state_q != LOCK_LOST);
      if (valid1_q) begin
        score_q <= score_nxt;
        if (epoch_q != 16'hFFFF) epoch_q <= epoch_q + 16'd1;
        if ((state_q == LOCK_IDLE || state_q == LOCK_PULL_IN) && pullin_left_q != '0)
          pullin_left_q <= pullin_left_q - 1'b1;
      end
    end
  end

  always_comb begin
    lock_state  = state_q;
    locked      = (state_q == LOCK_LOCKED);
    lost        = (state_q == LOCK_LOST);
    lost_strobe = lost_strobe_q;
    lock_score  = score_q;
    epoch_count = epoch_q;
  end

`ifdef CHANNEL_LOCK_HISTORY_EN
  logic [HIST_W-1:0] history_q;

  always_ff @(posedge clk) begin
    if (clear)         history_q <= '0;
    else if (valid1_q) history_q <= {history_q[HIST_W-2:0], pass};
  end

  assign lock_history = history_q;
`else
  assign lock_history = '0;
`endif

endmodule

// File: tb/tb_channel_lock_detector.sv
// Self-checking bench: directed scenarios plus randomized epochs against an epoch-level reference model.
module tb_channel_lock_detector;

  localparam int RATIO_SHIFT = 1;

  logic               clk = 1'b0;
  logic               reset_n, mode_reset, tracking_ready;
  logic signed [15:0] i_prompt_k, q_prompt_k;
  logic [31:0]        i2q2_prompt, power_thresh;
  logic [1:0]         lock_state;
  logic               locked, lost, lost_strobe;
  logic [5:0]         lock_score;
  logic [15:0]        epoch_count, lock_history;

  int checks = 0;
  int errors = 0;

  // reference model: state as 0 idle, 1 pull-in, 2 locked, 3 lost
  int     m_state, m_score, m_epochs, m_pull, m_strobe, m_hist;
  bit     p1_v;
  int     p1_i, p1_q;
  longint p1_p, p1_t;

  always #5 clk = ~clk;

  channel_lock_detector dut (
    .clk(clk), .reset_n(reset_n), .mode_reset(mode_reset), .tracking_ready(tracking_ready),
    .i_prompt_k(i_prompt_k), .q_prompt_k(q_prompt_k), .i2q2_prompt(i2q2_prompt),
    .power_thresh(power_thresh), .lock_state(lock_state), .locked(locked), .lost(lost),
    .lost_strobe(lost_strobe), .lock_score(lock_score), .epoch_count(epoch_count),
    .lock_history(lock_history)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mag(input int v);
    if (v < 0) return (v == -32768) ? 32767 : -v;
    return v;
  endfunction

  task automatic model_clear();
    m_state = 0; m_score = 0; m_epochs = 0; m_pull = 0; m_strobe = 0; m_hist = 0; p1_v = 0;
  endtask

  task automatic model_eval(input int i, input int q, input longint p, input longint t);
    int ai, aq;
    bit pass;
    ai   = mag(i);
    aq   = mag(q);
    pass = (ai > aq + (aq >> RATIO_SHIFT)) && (p >= t);
    if (pass) m_score = (m_score + 1 > 40) ? 40 : m_score + 1;
    else      m_score = (m_score - 2 < 0) ? 0 : m_score - 2;
    if (m_epochs < 65535) m_epochs++;
    m_hist = ((m_hist << 1) | int'(pass)) & 16'hFFFF;
    case (m_state)
      0: begin m_state = 1; m_pull = 1; end
      1: begin
        m_pull++;
        if (m_score >= 20) m_state = 2;
        else if (m_pull >= 200) begin m_state = 3; m_strobe = 1; end
      end
      2: if (m_score < 8) begin m_state = 3; m_strobe = 1; end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_eq("state", lock_state, m_state);
    check_eq("score", lock_score, m_score);
    check_eq("epochs", epoch_count, m_epochs);
    check_eq("lost_strobe", lost_strobe, m_strobe);
    check_eq("locked", locked, m_state == 2);
    check_eq("lost", lost, m_state == 3);
`ifdef CHANNEL_LOCK_HISTORY_EN
    check_eq("history", lock_history, m_hist);
`else
    check_eq("history", lock_history, 0);
`endif
  endtask

  task automatic step(input bit tr, input int i, input int q, input longint p, input longint t,
                      input bit mr);
    tracking_ready = tr;
    i_prompt_k     = 16'(i);
    q_prompt_k     = 16'(q);
    i2q2_prompt    = 32'(p);
    power_thresh   = 32'(t);
    mode_reset     = mr;
    @(posedge clk);
    m_strobe = 0;
    if (!reset_n || mr) begin
      model_clear();
    end else begin
      if (p1_v) model_eval(p1_i, p1_q, p1_p, p1_t);
      p1_v = tr; p1_i = i; p1_q = q; p1_p = p; p1_t = t;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic pass_strobe();
    step(1, 1000, 100, 5000, 4000, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_mode();
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int i, q, qm, good;
    longint p;
    reset_n = 1'b0; mode_reset = 1'b0; tracking_ready = 1'b0;
    i_prompt_k = '0; q_prompt_k = '0; i2q2_prompt = '0; power_thresh = '0;
    model_clear();
    @(negedge clk);

    // reset holds everything at zero even with strobes present
    step(1, 1000, 100, 5000, 4000, 0);
    step(1, 1000, 100, 5000, 4000, 0);
    check_eq("rst_state", lock_state, 0);
    reset_n = 1'b1;
    idle(5);
    check_eq("rst_idle", lock_state, 0);
    check_eq("rst_epochs", epoch_count, 0);

    // lock acquisition: 20 passing epochs
    repeat (20) pass_strobe();
    check_eq("acq_not_yet", locked, 0);
    idle(1);
    check_eq("acq_locked", locked, 1);
    check_eq("acq_score", lock_score, 20);

    // saturate, then decay with phase failures
    repeat (30) pass_strobe();
    idle(1);
    check_eq("sat_score", lock_score, 40);
    repeat (16) begin
      step(1, 1000, 1000, 5000, 4000, 0);
      idle(1);
    end
    check_eq("decay_score8", lock_score, 8);
    check_eq("decay_still_locked", locked, 1);
    step(1, 1000, 1000, 5000, 4000, 0);
    idle(1);
    check_eq("decay_lost", lock_state, 3);
    check_eq("decay_strobe", lost_strobe, 1);
    check_eq("decay_score6", lock_score, 6);
    idle(1);
    check_eq("decay_strobe_once", lost_strobe, 0);
    repeat (5) pass_strobe();
    idle(1);
    check_eq("lost_sticky", lock_state, 3);

    // pull-in timeout with power just under threshold
    clear_mode();
    repeat (200) step(1, 1000, 100, 3999, 4000, 0);
    check_eq("to_pullin", lock_state, 1);
    idle(1);
    check_eq("to_lost", lock_state, 3);
    check_eq("to_score", lock_score, 0);
    check_eq("to_epochs", epoch_count, 200);

    // mode_reset with a strobe in the same cycle
    clear_mode();
    repeat (20) pass_strobe();
    idle(1);
    check_eq("mr_locked", locked, 1);
    step(1, 1000, 100, 5000, 4000, 1);
    idle(1);
    check_eq("mr_same_state", lock_state, 0);
    check_eq("mr_same_epochs", epoch_count, 0);

    // mode_reset with an epoch sitting in stage 1
    repeat (20) pass_strobe();
    idle(1);
    pass_strobe();
    clear_mode();
    idle(1);
    check_eq("mr_s1_state", lock_state, 0);
    check_eq("mr_s1_score", lock_score, 0);

    // magnitude saturation, strict phase, inclusive power
    clear_mode();
    step(1, -32768, 0, 5000, 4000, 0);
    idle(1);
    check_eq("sat_abs_pass", lock_score, 1);
    step(1, 1500, 1000, 5000, 4000, 0);
    idle(1);
    check_eq("phase_strict", lock_score, 0);
    step(1, 1501, -1000, 4000, 4000, 0);
    idle(1);
    check_eq("power_incl", lock_score, 1);

    // randomized epochs in alternating good/bad regimes
    clear_mode();
    good = 1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 150 == 0) good = int'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      i = int'($urandom_range(0, 32767));
      if ($urandom_range(0, 1) == 1) i = -i;
      if ($urandom_range(0, 40) == 0) i = -32768;
      if (good == 1 && $urandom_range(0, 9) < 8) qm = mag(i) / int'($urandom_range(2, 8));
      else qm = int'($urandom_range(0, 32767));
      q = ($urandom_range(0, 1) == 1) ? -qm : qm;
      p = (good == 1) ? longint'($urandom_range(3990, 9000)) : longint'($urandom_range(3000, 4010));
      step($urandom_range(0, 3) != 0, i, q, p, 4000, $urandom_range(0, 299) == 0);
      reset_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
